// File: rtl/imem_fetch_arbiter.sv
// Instruction-memory fetch arbiter: shares the single-port block memory between the
// demand-miss refill path and the next-line prefetcher, one transaction at a time.
module imem_fetch_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int BLOCK_W = 128
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dm_req_valid,
    input  logic [ADDR_W-1:0]  dm_req_addr,
    output logic               dm_req_ready,
    output logic               dm_resp_valid,
    input  logic               pf_req_valid,
    input  logic [ADDR_W-1:0]  pf_req_addr,
    output logic               pf_req_ready,
    output logic               pf_resp_valid,
    input  logic               pf_cancel,
    output logic [ADDR_W-1:0]  resp_addr,
    output logic [BLOCK_W-1:0] resp_data,
    output logic               mem_ren,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [BLOCK_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nx_s;
    logic   owner_pf_r;
    logic   merge_r;
    logic   cancel_r;

    logic   dm_ready_s;
    logic   pf_ready_s;
    logic   accept_dm_s;
    logic   accept_pf_s;
    logic   merge_acc_s;
    logic   set_cancel_s;
    logic   capture_s;
    logic   dm_resp_nx_s;
    logic   pf_resp_nx_s;

    // Next-state, handshake and merge/cancel decisions.
    always_comb begin
        state_nx_s   = state_r;
        dm_ready_s   = 1'b0;
        pf_ready_s   = 1'b0;
        accept_dm_s  = 1'b0;
        accept_pf_s  = 1'b0;
        merge_acc_s  = 1'b0;
        set_cancel_s = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                dm_ready_s = 1'b1;
                pf_ready_s = ~dm_req_valid;
                if (dm_req_valid) begin
                    accept_dm_s = 1'b1;
                    state_nx_s  = ST_BUSY;
                end else if (pf_req_valid) begin
                    accept_pf_s  = 1'b1;
                    set_cancel_s = pf_cancel;
                    state_nx_s   = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A demand for the block the prefetcher is already fetching rides along.
                if (owner_pf_r && !merge_r && dm_req_valid && (dm_req_addr == mem_addr)) begin
                    dm_ready_s  = 1'b1;
                    merge_acc_s = 1'b1;
                end else begin
                    dm_ready_s  = 1'b0;
                    merge_acc_s = 1'b0;
                end
                set_cancel_s = owner_pf_r & pf_cancel;
                if (mem_ready) begin
                    capture_s  = 1'b1;
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    assign dm_resp_nx_s = capture_s & (~owner_pf_r | merge_r | merge_acc_s);
    assign pf_resp_nx_s = capture_s & owner_pf_r & ~(cancel_r | set_cancel_s);

    // Readies are forced low while reset is asserted so nothing is handshaken mid-reset.
    assign dm_req_ready = reset & dm_ready_s;
    assign pf_req_ready = reset & pf_ready_s;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Transaction owner plus sticky merge and cancel flags, cleared on every accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_pf_r <= 1'b0;
            merge_r    <= 1'b0;
            cancel_r   <= 1'b0;
        end else if (accept_dm_s || accept_pf_s) begin
            owner_pf_r <= accept_pf_s;
            merge_r    <= 1'b0;
            cancel_r   <= set_cancel_s;
        end else begin
            if (merge_acc_s) begin
                merge_r <= 1'b1;
            end
            if (set_cancel_s) begin
                cancel_r <= 1'b1;
            end
        end
    end

    // Memory request: ren rises on accept and falls on capture, so RESP always has it low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_ren  <= 1'b0;
            mem_addr <= {ADDR_W{1'b0}};
        end else if (accept_dm_s) begin
            mem_ren  <= 1'b1;
            mem_addr <= dm_req_addr;
        end else if (accept_pf_s) begin
            mem_ren  <= 1'b1;
            mem_addr <= pf_req_addr;
        end else if (capture_s) begin
            mem_ren  <= 1'b0;
        end
    end

    // Response block, held until the next capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_addr <= {ADDR_W{1'b0}};
            resp_data <= {BLOCK_W{1'b0}};
        end else if (capture_s) begin
            resp_addr <= mem_addr;
            resp_data <= mem_dout;
        end
    end

    // One-cycle response pulses, high exactly in the RESP cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dm_resp_valid <= 1'b0;
            pf_resp_valid <= 1'b0;
        end else begin
            dm_resp_valid <= dm_resp_nx_s;
            pf_resp_valid <= pf_resp_nx_s;
        end
    end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: 3-cycle memory model, transaction-level timing reference,
// directed scenario table, reset-in-flight sequence and a randomized run.
module tb_imem_fetch_arbiter;

    localparam int AW = 10;
    localparam int BW = 128;

    logic          clock = 1'b0;
    logic          reset;
    logic          dm_req_valid, dm_req_ready, dm_resp_valid;
    logic [AW-1:0] dm_req_addr;
    logic          pf_req_valid, pf_req_ready, pf_resp_valid, pf_cancel;
    logic [AW-1:0] pf_req_addr;
    logic [AW-1:0] resp_addr, mem_addr;
    logic [BW-1:0] resp_data, mem_dout;
    logic          mem_ren, mem_ready;

    imem_fetch_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
        .clock(clock), .reset(reset),
        .dm_req_valid(dm_req_valid), .dm_req_addr(dm_req_addr), .dm_req_ready(dm_req_ready),
        .dm_resp_valid(dm_resp_valid),
        .pf_req_valid(pf_req_valid), .pf_req_addr(pf_req_addr), .pf_req_ready(pf_req_ready),
        .pf_resp_valid(pf_resp_valid), .pf_cancel(pf_cancel),
        .resp_addr(resp_addr), .resp_data(resp_data),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;

    function automatic logic [BW-1:0] blk(input logic [AW-1:0] a);
        blk = {6'h11, a, 16'hBEEF, 6'h22, a, 16'hCAFE, 6'h33, a, 16'hF00D, 6'h3C, a, 16'h1234};
    endfunction

    // Memory: delay counter restarts whenever ren is low; ready is registered.
    logic [1:0] mcnt;
    always @(posedge clock) begin
        if (!mem_ren) begin
            mcnt      <= 2'd0;
            mem_ready <= 1'b0;
        end else if (mcnt == 2'd2) begin
            mem_ready <= 1'b1;
            mem_dout  <= blk(mem_addr);
        end else begin
            mcnt      <= mcnt + 2'd1;
            mem_ready <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction-level reference: accepted at cycle A, memory busy A+1..A+4, response at A+5.
    bit            tx_v, tx_pf, tx_mrg, tx_can;
    int            tx_acc;
    logic [AW-1:0] tx_addr;
    logic [AW-1:0] last_addr;
    logic [BW-1:0] last_data;
    bit            o_dm, o_pf, o_ren;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        tx_v      = 1'b0;
        last_addr = '0;
        last_data = '0;
    endtask

    // One cycle: inputs already driven at the negedge; compare, update model, advance.
    task automatic step();
        bit idle, busy, resp, e_dm_rdy, e_pf_rdy, saw_dm, saw_pf;
        #1;
        if (tx_v && cyc >= tx_acc + 6) tx_v = 1'b0;
        idle = !tx_v;
        busy = tx_v && (cyc <= tx_acc + 4);
        resp = tx_v && (cyc == tx_acc + 5);
        e_dm_rdy = idle || (busy && tx_pf && !tx_mrg && dm_req_valid && (dm_req_addr == tx_addr));
        e_pf_rdy = idle && !dm_req_valid;
        if (resp) begin
            last_addr = tx_addr;
            last_data = blk(tx_addr);
        end
        chk("dm_req_ready", dm_req_ready, e_dm_rdy);
        chk("pf_req_ready", pf_req_ready, e_pf_rdy);
        chk("mem_ren", mem_ren, busy);
        chk("dm_resp_valid", dm_resp_valid, resp && (!tx_pf || tx_mrg));
        chk("pf_resp_valid", pf_resp_valid, resp && tx_pf && !tx_can);
        chk("resp_addr", resp_addr, last_addr);
        chk("resp_data", resp_data, last_data);
        if (busy) chk("mem_addr", mem_addr, tx_addr);
        o_dm   = dm_resp_valid;
        o_pf   = pf_resp_valid;
        o_ren  = mem_ren;
        saw_dm = dm_req_ready;
        saw_pf = pf_req_ready;
        if (busy && tx_pf && pf_cancel) tx_can = 1'b1;
        if (busy && e_dm_rdy) tx_mrg = 1'b1;
        if (idle && dm_req_valid) begin
            tx_v = 1'b1; tx_pf = 1'b0; tx_mrg = 1'b0; tx_can = 1'b0;
            tx_acc = cyc; tx_addr = dm_req_addr;
        end else if (idle && pf_req_valid) begin
            tx_v = 1'b1; tx_pf = 1'b1; tx_mrg = 1'b0; tx_can = pf_cancel;
            tx_acc = cyc; tx_addr = pf_req_addr;
        end
        @(posedge clock);
        @(negedge clock);
        if (saw_dm) dm_req_valid = 1'b0;
        if (saw_pf) pf_req_valid = 1'b0;
        cyc++;
    endtask

    typedef struct {
        string         name;
        int            dm_at;
        logic [AW-1:0] dm_addr;
        int            pf_at;
        logic [AW-1:0] pf_addr;
        int            cancel_at;
        int            exp_dm;
        int            exp_pf;
        int            exp_ren;
    } scen_t;

    scen_t tbl[10];

    // Runs a 16-cycle window; records first response cycles and total ren-high cycles.
    task automatic run_scen(input scen_t s);
        int first_dm, first_pf, nren;
        first_dm = -1; first_pf = -1; nren = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == s.dm_at) begin dm_req_valid = 1'b1; dm_req_addr = s.dm_addr; end
            if (k == s.pf_at) begin pf_req_valid = 1'b1; pf_req_addr = s.pf_addr; end
            pf_cancel = (k == s.cancel_at);
            step();
            if (o_dm && first_dm < 0) first_dm = k;
            if (o_pf && first_pf < 0) first_pf = k;
            if (o_ren) nren++;
        end
        pf_cancel = 1'b0;
        chk_int({s.name, " dm_resp cycle"}, first_dm, s.exp_dm);
        chk_int({s.name, " pf_resp cycle"}, first_pf, s.exp_pf);
        chk_int({s.name, " ren cycles"}, nren, s.exp_ren);
    endtask

    initial begin
        tbl[0] = '{"dm alone",        0, 10'h012, -1, 10'h000, -1,  5, -1, 4};
        tbl[1] = '{"dm beats pf",     0, 10'h020,  0, 10'h021, -1,  5, 11, 8};
        tbl[2] = '{"merge same addr", 2, 10'h030,  0, 10'h030, -1,  5,  5, 4};
        tbl[3] = '{"dm other addr",   2, 10'h041,  0, 10'h040, -1, 11,  5, 8};
        tbl[4] = '{"cancel mid busy", 6, 10'h051,  0, 10'h050,  2, 11, -1, 8};
        tbl[5] = '{"cancel on accept",-1, 10'h000, 0, 10'h052,  0, -1, -1, 4};
        tbl[6] = '{"cancel in idle",  -1, 10'h000, 3, 10'h053,  0, -1,  8, 4};
        tbl[7] = '{"merge ready cyc", 4, 10'h060,  0, 10'h060, -1,  5,  5, 4};
        tbl[8] = '{"dm in resp cyc",  5, 10'h061,  0, 10'h061, -1, 11,  5, 8};
        tbl[9] = '{"merge+cancel",    1, 10'h070,  0, 10'h070,  3,  5, -1, 4};

        reset = 1'b0;
        dm_req_valid = 1'b0; dm_req_addr = '0;
        pf_req_valid = 1'b0; pf_req_addr = '0;
        pf_cancel = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        dm_req_valid = 1'b1;
        #1;
        chk("reset dm_req_ready", dm_req_ready, 1'b0);
        chk("reset pf_req_ready", pf_req_ready, 1'b0);
        chk("reset mem_ren", mem_ren, 1'b0);
        chk("reset mem_addr", mem_addr, '0);
        chk("reset resp_valids", {dm_resp_valid, pf_resp_valid}, 2'b00);
        chk("reset resp_data", resp_data, '0);
        dm_req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_scen(tbl[i]);

        // Reset while a demand is in flight.
        dm_req_valid = 1'b1; dm_req_addr = 10'h00A;
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        chk("midreset mem_ren", mem_ren, 1'b0);
        chk("midreset dm_req_ready", dm_req_ready, 1'b0);
        chk("midreset pf_req_ready", pf_req_ready, 1'b0);
        chk("midreset resp_valids", {dm_resp_valid, pf_resp_valid}, 2'b00);
        chk("midreset resp_addr", resp_addr, '0);
        dm_req_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_reset();
        run_scen('{"after reset", 0, 10'h005, -1, 10'h000, -1, 5, -1, 4});

        // Randomized traffic on a small address set to provoke merges and waits.
        for (int n = 0; n < 400; n++) begin
            if (!dm_req_valid && $urandom_range(0, 3) == 0) begin
                dm_req_valid = 1'b1;
                dm_req_addr  = 10'h100 + 10'($urandom_range(0, 3));
            end
            if (!pf_req_valid && $urandom_range(0, 2) == 0) begin
                pf_req_valid = 1'b1;
                pf_req_addr  = 10'h100 + 10'($urandom_range(0, 3));
            end
            pf_cancel = ($urandom_range(0, 7) == 0);
            step();
        end
        pf_cancel = 1'b0;
        for (int n = 0; n < 24; n++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
